oam_dma: RTL and testbench

// - Sprite OAM DMA controller on the CPU bus. A CPU write to $4014 holds value P.
//   The block then stalls the CPU and copies 256 bytes from $P00-$PFF into PPU

---
 rtl/nes_pkg.sv | 15 +
 rtl/oam_dma.sv | 116 +++++++++++
 tb/tb_oam_dma.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding and CPU-bus register addresses.
package nes_pkg;

   typedef enum logic [2:0] {
      DMA_IDLE,
      DMA_HALT,
      DMA_ALIGN,
      DMA_READ,
      DMA_WRITE
   } dma_state_t;

   localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
   localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to the DMA register stalls the CPU and copies a page
// into PPU OAMDATA as alternating get/put cycles.
module oam_dma
   import nes_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
   parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
   parameter int unsigned XFER_LEN      = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rw,
   input  logic [7:0]  cpu_data_o,
   output logic        cpu_halt,
   output logic        dma_active,
   output logic [15:0] bus_addr,
   output logic        bus_rw,
   output logic [7:0]  bus_data_o,
   input  logic [7:0]  bus_data_i
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   dma_state_t  state_q, state_d;
   logic        parity_q;
   logic [7:0]  page_q, page_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  latch_q, latch_d;

   logic        cpu_halt_d;
   logic        dma_active_d;
   logic [15:0] bus_addr_d;
   logic        bus_rw_d;
   logic [7:0]  bus_data_d;

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      latch_d = latch_q;
      unique case (state_q)
         DMA_IDLE: begin
            if (!cpu_rw && cpu_addr == DMA_REG_ADDR) begin
               page_d  = cpu_data_o;
               state_d = DMA_HALT;
            end
         end
         DMA_HALT: begin
            // The next cycle's parity is ~parity_q; reads must land on get cycles.
            if (cpu_rw) state_d = parity_q ? DMA_READ : DMA_ALIGN;
         end
         DMA_ALIGN: state_d = DMA_READ;
         DMA_READ: begin
            latch_d = bus_data_i;
            state_d = DMA_WRITE;
         end
         DMA_WRITE: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = DMA_IDLE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = DMA_READ;
            end
         end
         default: state_d = DMA_IDLE;
      endcase
   end

   // Outputs are decoded from next-state values so the registered copies line up with state_q.
   always_comb begin
      cpu_halt_d   = (state_d != DMA_IDLE);
      dma_active_d = (state_d == DMA_ALIGN) || (state_d == DMA_READ) || (state_d == DMA_WRITE);
      bus_addr_d   = '0;
      bus_rw_d     = 1'b1;
      bus_data_d   = '0;
      case (state_d)
         DMA_ALIGN: bus_addr_d = {page_d, 8'h00};
         DMA_READ:  bus_addr_d = {page_d, idx_d};
         DMA_WRITE: begin
            bus_addr_d = OAM_DATA_ADDR;
            bus_rw_d   = 1'b0;
            bus_data_d = latch_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= DMA_IDLE;
         parity_q   <= 1'b0;
         page_q     <= '0;
         idx_q      <= '0;
         latch_q    <= '0;
         cpu_halt   <= 1'b0;
         dma_active <= 1'b0;
         bus_addr   <= '0;
         bus_rw     <= 1'b1;
         bus_data_o <= '0;
      end else begin
         state_q    <= state_d;
         parity_q   <= ~parity_q;
         page_q     <= page_d;
         idx_q      <= idx_d;
         latch_q    <= latch_d;
         cpu_halt   <= cpu_halt_d;
         dma_active <= dma_active_d;
         bus_addr   <= bus_addr_d;
         bus_rw     <= bus_rw_d;
         bus_data_o <= bus_data_d;
      end
   end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a 256-byte and a 4-byte instance share the CPU bus and are
// checked against an expected bus-cycle list built from page, trigger cycle and hold.
module tb_oam_dma;
   import nes_pkg::*;

   typedef struct packed {
      logic [15:0] addr;
      logic        rw;
      logic [7:0]  data;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr;
   logic        cpu_rw;
   logic [7:0]  cpu_data_o;

   logic        halt0, act0, rw0, halt1, act1, rw1;
   logic [15:0] addr0, addr1;
   logic [7:0]  dout0, dout1, din0, din1;

   logic [7:0]  mem [65536];
   txn_t        obs0[$], obs1[$];
   int          halt_cnt0, halt_cnt1, pre0, pre1;
   int          cyc;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   oam_dma dut0 (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_data_o(cpu_data_o),
      .cpu_halt(halt0), .dma_active(act0), .bus_addr(addr0), .bus_rw(rw0),
      .bus_data_o(dout0), .bus_data_i(din0)
   );

   oam_dma #(.XFER_LEN(4)) dut1 (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_data_o(cpu_data_o),
      .cpu_halt(halt1), .dma_active(act1), .bus_addr(addr1), .bus_rw(rw1),
      .bus_data_o(dout1), .bus_data_i(din1)
   );

   assign din0 = mem[addr0];
   assign din1 = mem[addr1];

   // Cycle index since reset release; its LSB is the get/put parity.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (act0) obs0.push_back({addr0, rw0, rw0 ? 8'h00 : dout0});
      if (act1) obs1.push_back({addr1, rw1, rw1 ? 8'h00 : dout1});
      if (halt0) halt_cnt0++;
      if (halt1) halt_cnt1++;
      if (halt0 && !act0) pre0++;
      if (halt1 && !act1) pre1++;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic start_dma(input logic [7:0] p, input int par, input int hold, input bit inject,
                            output int t);
      @(posedge clk); #1;
      if ((cyc % 2) != par) begin
         @(posedge clk); #1;
      end
      obs0.delete(); obs1.delete();
      halt_cnt0 = 0; halt_cnt1 = 0; pre0 = 0; pre1 = 0;
      t = cyc;
      cpu_addr = ADDR_OAMDMA; cpu_rw = 1'b0; cpu_data_o = p;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         cpu_addr = 16'h01FD; cpu_rw = 1'b0; cpu_data_o = 8'h55;
      end
      @(posedge clk); #1;
      cpu_addr = 16'h8000; cpu_rw = 1'b1;
      if (inject) begin
         repeat (3) @(posedge clk);
         #1;
         cpu_addr = ADDR_OAMDMA; cpu_rw = 1'b0; cpu_data_o = 8'h03;
         @(posedge clk); #1;
         cpu_addr = 16'h8000; cpu_rw = 1'b1;
      end
   endtask

   task automatic verify(input string tag, input txn_t obs[$], input int halts, input int pre,
                         input int len, input int t, input int hold, input logic [7:0] p);
      txn_t exp[$];
      int   h;
      bit   align;
      h = t + 1 + hold;
      align = ((h + 1) % 2) == 1;
      if (align) exp.push_back({p, 8'h00, 1'b1, 8'h00});
      for (int i = 0; i < len; i++) begin
         logic [15:0] a;
         a = {p, 8'(i)};
         exp.push_back({a, 1'b1, 8'h00});
         exp.push_back({ADDR_OAMDATA, 1'b0, mem[a]});
      end
      check({tag, " stall cycles"}, halts, hold + 1 + int'(align) + 2 * len);
      check({tag, " halt before bus"}, pre, hold + 1);
      check({tag, " bus cycles"}, obs.size(), exp.size());
      for (int i = 0; i < exp.size() && i < obs.size(); i++)
         check($sformatf("%s cycle %0d", tag, i), obs[i], exp[i]);
   endtask

   task automatic run_dma(input logic [7:0] p, input int par, input int hold, input bit inject);
      int t;
      bit timed_out;
      start_dma(p, par, hold, inject, t);
      timed_out = 1'b1;
      for (int n = 0; n < 1200; n++) begin
         @(posedge clk); #1;
         if (!halt0 && !halt1) begin
            timed_out = 1'b0;
            break;
         end
      end
      check("dma completes", 32'(timed_out), 0);
      verify($sformatf("len256 p=%02h", p), obs0, halt_cnt0, pre0, 256, t, hold, p);
      verify($sformatf("len4 p=%02h", p), obs1, halt_cnt1, pre1, 4, t, hold, p);
   endtask

   initial begin
      int t, writes;
      logic [15:0] a;
      rst = 1'b1;
      cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_data_o = 8'h00;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      #1;
      check("reset cpu_halt", 32'(halt0), 0);
      check("reset dma_active", 32'(act0), 0);
      check("reset bus_addr", 32'(addr0), 0);
      check("reset bus_rw", 32'(rw0), 1);
      check("reset bus_data_o", 32'(dout0), 0);
      check("reset len4 cpu_halt", 32'(halt1), 0);
      #11 rst = 1'b0;

      run_dma(8'h02, 0, 0, 1'b0);
      run_dma(8'h02, 1, 0, 1'b0);
      run_dma(8'h02, 0, 2, 1'b0);
      run_dma(8'h02, 1, 0, 1'b1);
      run_dma(8'hFF, 0, 0, 1'b0);
      run_dma(8'hFF, 1, 1, 1'b0);

      // Random non-trigger traffic must leave both blocks idle.
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         a = 16'($urandom);
         if (a == ADDR_OAMDMA) a = 16'h4015;
         cpu_addr = (i % 4 == 0) ? ADDR_OAMDMA : a;
         cpu_rw = (i % 4 == 0) ? 1'b1 : 1'($urandom);
         cpu_data_o = 8'($urandom);
      end
      @(posedge clk); #1;
      cpu_addr = 16'h8000; cpu_rw = 1'b1;
      check("idle after stray traffic", {30'd0, halt0, halt1}, 0);

      for (int r = 0; r < 4; r++)
         run_dma(8'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom));

      // Reset while the 256-byte transfer is reading byte 100.
      start_dma(8'h02, 0, 0, 1'b0, t);
      repeat (201) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid-dma reset dma_active", 32'(act0), 0);
      check("mid-dma reset cpu_halt", 32'(halt0), 0);
      check("mid-dma reset bus_addr", 32'(addr0), 0);
      check("mid-dma reset bus_rw", 32'(rw0), 1);
      writes = 0;
      foreach (obs0[i]) if (!obs0[i].rw) writes++;
      check("bytes written before reset", writes, 100);
      @(negedge clk);
      rst = 1'b0;
      run_dma(8'h02, 1, 0, 1'b0);
      run_dma(8'h7C, 0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
